// File: rtl/fp_minmax_sched.sv
// Round-robin sequencer sharing one combinational FP add/sub/min/max datapath
// between two requesters; operands are held for DP_LAT cycles, then the result is returned.
module fp_minmax_sched #(
   parameter int XLEN   = 32,
   parameter int DP_LAT = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req0_valid,
   output logic            req0_ready,
   input  logic [1:0]      req0_op,
   input  logic [XLEN-1:0] req0_a,
   input  logic [XLEN-1:0] req0_b,
   input  logic            req1_valid,
   output logic            req1_ready,
   input  logic [1:0]      req1_op,
   input  logic [XLEN-1:0] req1_a,
   input  logic [XLEN-1:0] req1_b,
   output logic            rsp0_valid,
   input  logic            rsp0_ready,
   output logic            rsp1_valid,
   input  logic            rsp1_ready,
   output logic [XLEN-1:0] rsp_data,
   output logic [XLEN-1:0] dp_frs1,
   output logic [XLEN-1:0] dp_frs2,
   output logic            dp_funct,
   output logic            dp_en,
   input  logic [XLEN-1:0] dp_frd,
   input  logic [XLEN-1:0] dp_min,
   input  logic [XLEN-1:0] dp_max,
   output logic            busy
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t          state_reg, state_next;
   logic            last_grant_reg, last_grant_next;
   logic            owner_reg, owner_next;
   logic [3:0]      cnt_reg, cnt_next;
   logic [1:0]      op_reg, op_next;
   logic [XLEN-1:0] frs1_reg, frs1_next;
   logic [XLEN-1:0] frs2_reg, frs2_next;
   logic [XLEN-1:0] rsp_data_reg, rsp_data_next;

   logic [1:0]      req_valid, req_ready, rsp_valid, rsp_ready;
   logic [1:0]      req_op [2];
   logic [XLEN-1:0] req_a  [2];
   logic [XLEN-1:0] req_b  [2];
   logic            grant_any, grant_id;

   assign req_valid = {req1_valid, req0_valid};
   assign rsp_ready = {rsp1_ready, rsp0_ready};
   assign req_op[0] = req0_op;
   assign req_op[1] = req1_op;
   assign req_a[0]  = req0_a;
   assign req_a[1]  = req1_a;
   assign req_b[0]  = req0_b;
   assign req_b[1]  = req1_b;

   // On contention the requester that did not win last time is served.
   assign grant_any = |req_valid;
   assign grant_id  = (&req_valid) ? ~last_grant_reg : req_valid[1];

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_chan
         assign req_ready[gi] = (state_reg == IDLE) && grant_any && (grant_id == 1'(gi));
         assign rsp_valid[gi] = (state_reg == RESP) && (owner_reg == 1'(gi));
      end
   endgenerate

   assign req0_ready = req_ready[0];
   assign req1_ready = req_ready[1];
   assign rsp0_valid = rsp_valid[0];
   assign rsp1_valid = rsp_valid[1];
   assign rsp_data   = rsp_data_reg;
   assign dp_frs1    = frs1_reg;
   assign dp_frs2    = frs2_reg;
   assign dp_en      = (state_reg == EXEC);
   // MIN/MAX come from the sign of frs1-frs2, so the datapath must subtract for them too.
   assign dp_funct   = dp_en && (op_reg[1] || op_reg[0]);
   assign busy       = (state_reg != IDLE);

   always_comb begin
      state_next      = state_reg;
      last_grant_next = last_grant_reg;
      owner_next      = owner_reg;
      cnt_next        = cnt_reg;
      op_next         = op_reg;
      frs1_next       = frs1_reg;
      frs2_next       = frs2_reg;
      rsp_data_next   = rsp_data_reg;
      case (state_reg)
         IDLE: begin
            if (grant_any) begin
               frs1_next       = req_a[grant_id];
               frs2_next       = req_b[grant_id];
               op_next         = req_op[grant_id];
               owner_next      = grant_id;
               last_grant_next = grant_id;
               cnt_next        = 4'(DP_LAT - 1);
               state_next      = EXEC;
            end
         end
         EXEC: begin
            if (cnt_reg == 4'd0) begin
               case (op_reg)
                  2'b10:   rsp_data_next = dp_min;
                  2'b11:   rsp_data_next = dp_max;
                  default: rsp_data_next = dp_frd;
               endcase
               state_next = RESP;
            end else begin
               cnt_next = cnt_reg - 4'd1;
            end
         end
         RESP: begin
            if (rsp_ready[owner_reg]) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg      <= IDLE;
         last_grant_reg <= 1'b1;
         owner_reg      <= 1'b0;
         cnt_reg        <= 4'd0;
         op_reg         <= 2'b00;
         frs1_reg       <= '0;
         frs2_reg       <= '0;
         rsp_data_reg   <= '0;
      end else begin
         state_reg      <= state_next;
         last_grant_reg <= last_grant_next;
         owner_reg      <= owner_next;
         cnt_reg        <= cnt_next;
         op_reg         <= op_next;
         frs1_reg       <= frs1_next;
         frs2_reg       <= frs2_next;
         rsp_data_reg   <= rsp_data_next;
      end
   end

endmodule

// File: tb/tb_fp_minmax_sched.sv
// Directed bench for fp_minmax_sched: scoreboard of expected responses filled at grant,
// drained at each response handshake; a second instance covers DP_LAT=1.
module tb_fp_minmax_sched;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;
   int   cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        req0_valid, req0_ready, req1_valid, req1_ready;
   logic [1:0]  req0_op, req1_op;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
   logic [31:0] rsp_data, dp_frs1, dp_frs2, dp_frd, dp_min, dp_max;
   logic        dp_funct, dp_en, busy;

   logic        b_req0_valid, b_req0_ready, b_req1_valid, b_req1_ready;
   logic [1:0]  b_req0_op, b_req1_op;
   logic [31:0] b_req0_a, b_req0_b, b_req1_a, b_req1_b;
   logic        b_rsp0_valid, b_rsp0_ready, b_rsp1_valid, b_rsp1_ready;
   logic [31:0] b_rsp_data, b_dp_frs1, b_dp_frs2, b_dp_frd, b_dp_min, b_dp_max;
   logic        b_dp_funct, b_dp_en, b_busy;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic        id;
      logic [31:0] data;
   } exp_t;
   exp_t sb[$];
   int   gnt_log[$];

   // Datapath stand-in: float ordering for min/max, a tagged add/sub token otherwise.
   function automatic logic fp_lt(logic [31:0] x, logic [31:0] y);
      if (x[31] != y[31]) return x[31];
      if (x[31]) return x > y;
      return x < y;
   endfunction

   function automatic logic [31:0] model_frd(logic [31:0] x, logic [31:0] y, logic f);
      if (!f && x == 32'h3F800000 && y == 32'h40000000) return 32'h40400000;
      return f ? x - y : x + y;
   endfunction

   function automatic logic [31:0] exp_res(logic [1:0] op, logic [31:0] x, logic [31:0] y);
      case (op)
         2'b00:   return model_frd(x, y, 1'b0);
         2'b01:   return model_frd(x, y, 1'b1);
         2'b10:   return fp_lt(x, y) ? x : y;
         default: return fp_lt(x, y) ? y : x;
      endcase
   endfunction

   assign dp_frd   = model_frd(dp_frs1, dp_frs2, dp_funct);
   assign dp_min   = fp_lt(dp_frs1, dp_frs2) ? dp_frs1 : dp_frs2;
   assign dp_max   = fp_lt(dp_frs1, dp_frs2) ? dp_frs2 : dp_frs1;
   assign b_dp_frd = model_frd(b_dp_frs1, b_dp_frs2, b_dp_funct);
   assign b_dp_min = fp_lt(b_dp_frs1, b_dp_frs2) ? b_dp_frs1 : b_dp_frs2;
   assign b_dp_max = fp_lt(b_dp_frs1, b_dp_frs2) ? b_dp_frs2 : b_dp_frs1;

   fp_minmax_sched #(.XLEN(32), .DP_LAT(2)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
      .req1_a(req1_a), .req1_b(req1_b),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp_data(rsp_data), .dp_frs1(dp_frs1), .dp_frs2(dp_frs2),
      .dp_funct(dp_funct), .dp_en(dp_en), .dp_frd(dp_frd),
      .dp_min(dp_min), .dp_max(dp_max), .busy(busy)
   );

   fp_minmax_sched #(.XLEN(32), .DP_LAT(1)) u_dut_lat1 (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(b_req0_valid), .req0_ready(b_req0_ready), .req0_op(b_req0_op),
      .req0_a(b_req0_a), .req0_b(b_req0_b),
      .req1_valid(b_req1_valid), .req1_ready(b_req1_ready), .req1_op(b_req1_op),
      .req1_a(b_req1_a), .req1_b(b_req1_b),
      .rsp0_valid(b_rsp0_valid), .rsp0_ready(b_rsp0_ready),
      .rsp1_valid(b_rsp1_valid), .rsp1_ready(b_rsp1_ready),
      .rsp_data(b_rsp_data), .dp_frs1(b_dp_frs1), .dp_frs2(b_dp_frs2),
      .dp_funct(b_dp_funct), .dp_en(b_dp_en), .dp_frd(b_dp_frd),
      .dp_min(b_dp_min), .dp_max(b_dp_max), .busy(b_busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   function automatic logic [6:0] ctl_outs();
      return {req0_ready, req1_ready, rsp0_valid, rsp1_valid, dp_funct, dp_en, busy};
   endfunction

   task automatic pop_chk(input logic ch);
      exp_t e;
      if (sb.size() == 0) begin
         chk("rsp_unexpected", 32'(ch), 32'hFFFF_FFFF);
      end else begin
         e = sb.pop_front();
         chk("rsp_channel", 32'(ch), 32'(e.id));
         chk("rsp_data", rsp_data, e.data);
         $display("txn rsp ch=%0d data=%h cyc=%0d", ch, rsp_data, cyc);
      end
   endtask

   // Called at posedge+1 after inputs are driven; records grants, checks handshakes, advances a cycle.
   task automatic step();
      #1;
      if (req0_ready) begin
         sb.push_back('{id: 1'b0, data: exp_res(req0_op, req0_a, req0_b)});
         gnt_log.push_back(0);
      end
      if (req1_ready) begin
         sb.push_back('{id: 1'b1, data: exp_res(req1_op, req1_a, req1_b)});
         gnt_log.push_back(1);
      end
      if (rsp0_valid && rsp0_ready) pop_chk(1'b0);
      if (rsp1_valid && rsp1_ready) pop_chk(1'b1);
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n = 0;
      while ((sb.size() != 0 || busy) && n < 30) begin
         step();
         n++;
      end
      chk("drain_timeout", 32'(n < 30), 32'd1);
   endtask

   initial begin
      int n;
      int b_t[$];
      rst_n = 1'b0;
      req0_valid = 0; req0_op = 0; req0_a = 0; req0_b = 0;
      req1_valid = 0; req1_op = 0; req1_a = 0; req1_b = 0;
      rsp0_ready = 0; rsp1_ready = 0;
      b_req0_valid = 0; b_req0_op = 0; b_req0_a = 0; b_req0_b = 0;
      b_req1_valid = 0; b_req1_op = 0; b_req1_a = 0; b_req1_b = 0;
      b_rsp0_ready = 1; b_rsp1_ready = 0;

      // Reset and idle
      repeat (3) begin
         @(posedge clk); #1;
         chk("reset_ctl", 32'(ctl_outs()), 32'd0);
      end
      rst_n = 1'b1;
      repeat (5) step();
      chk("idle_ctl", 32'(ctl_outs()), 32'd0);
      chk("idle_data", dp_frs1 | dp_frs2 | rsp_data, 32'd0);

      // Single add on requester 0
      rsp0_ready = 1; rsp1_ready = 1;
      req0_valid = 1; req0_op = 2'b00; req0_a = 32'h3F800000; req0_b = 32'h40000000;
      #1 chk("add_ready", 32'(req0_ready), 32'd1);
      step();
      req0_valid = 0;
      chk("add_frs1", dp_frs1, 32'h3F800000);
      chk("add_frs2", dp_frs2, 32'h40000000);
      chk("add_en_funct", {30'd0, dp_en, dp_funct}, 32'b10);
      step();
      step();
      chk("add_rsp_valid", {30'd0, rsp0_valid, rsp1_valid}, 32'b10);
      chk("add_rsp_data", rsp_data, 32'h40400000);
      step();
      chk("add_idle", 32'(busy), 32'd0);

      // Max on requester 1 with response backpressure; requester 0 waits meanwhile
      rsp1_ready = 0;
      req1_valid = 1; req1_op = 2'b11; req1_a = 32'hC0000000; req1_b = 32'h3F800000;
      step();
      req1_valid = 0;
      req0_valid = 1; req0_op = 2'b00; req0_a = 32'h00000001; req0_b = 32'h00000002;
      chk("max_funct", {30'd0, dp_en, dp_funct}, 32'b11);
      step();
      step();
      repeat (5) begin
         chk("bp_ctl", 32'(ctl_outs()), 32'b0001001);
         chk("bp_data", rsp_data, 32'h3F800000);
         step();
      end
      rsp1_ready = 1;
      #1 chk("bp_no_grant_at_hs", 32'(req0_ready), 32'd0);
      step();
      chk("post_hs_grant", 32'(req0_ready), 32'd1);
      step();
      req0_valid = 0;
      drain();

      // Asynchronous reset while an op is executing
      req1_valid = 1; req1_op = 2'b00; req1_a = 32'h00000010; req1_b = 32'h00000020;
      step();
      req1_valid = 0;
      chk("arst_exec", 32'(dp_en), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_ctl", 32'(ctl_outs()), 32'd0);
      chk("arst_data", dp_frs1 | dp_frs2 | rsp_data, 32'd0);
      sb.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (4) begin
         chk("arst_no_rsp", {30'd0, rsp0_valid, rsp1_valid}, 32'd0);
         step();
      end

      // Contention: both requesters always valid, expect alternation starting at 0
      gnt_log.delete();
      req0_valid = 1; req0_op = 2'b10; req0_a = 32'h40400000; req0_b = 32'hBF800000;
      req1_valid = 1; req1_op = 2'b01; req1_a = 32'h00000010; req1_b = 32'h00000003;
      n = 0;
      while (gnt_log.size() < 4 && n < 40) begin
         step();
         n++;
      end
      req0_valid = 0; req1_valid = 0;
      chk("cont_timeout", 32'(n < 40), 32'd1);
      for (int i = 0; i < 4; i++)
         chk($sformatf("cont_grant%0d", i), 32'(gnt_log.size() > i ? gnt_log[i] : -1), 32'(i % 2));
      drain();

      // DP_LAT=1 instance: back-to-back subs, one issue every 3 cycles
      b_req0_valid = 1; b_req0_op = 2'b01; b_req0_a = 32'h00000005; b_req0_b = 32'h00000002;
      n = 0;
      while (b_t.size() < 3 && n < 20) begin
         #1;
         if (b_req0_ready) b_t.push_back(cyc);
         if (b_dp_en) chk("lat1_funct", 32'(b_dp_funct), 32'd1);
         if (b_rsp0_valid) begin
            chk("lat1_rsp", b_rsp_data, 32'h00000003);
            $display("txn lat1 rsp ch=0 data=%h cyc=%0d", b_rsp_data, cyc);
         end
         @(posedge clk); #1;
         n++;
      end
      b_req0_valid = 0;
      chk("lat1_timeout", 32'(b_t.size()), 32'd3);
      if (b_t.size() == 3) begin
         chk("lat1_gap0", 32'(b_t[1] - b_t[0]), 32'd3);
         chk("lat1_gap1", 32'(b_t[2] - b_t[1]), 32'd3);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fp_minmax_sched.md
Name: fp_minmax_sched

Overview:
- Sequencer/arbiter sharing one floating-point add/sub/min/max datapath between two requesters.
- Accepts ops over valid/ready, round-robin arbitrates, holds operands stable on the datapath for a fixed settle time, captures the selected result, returns it over a per-requester response handshake.
- Sits between issue logic and the combinational FP min/max/add-sub unit in the floating ALU.

Parameters:
- XLEN, 32, operand/result width.
- DP_LAT, 2, cycles operands are held before result sampling; legal 1..15.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset.
- req0_valid  input  1  requester 0 op valid.
- req0_ready  output  1  requester 0 op accepted this cycle.
- req0_op  input  2  00 add, 01 sub, 10 min, 11 max.
- req0_a  input  XLEN  operand a (frs1).
- req0_b  input  XLEN  operand b (frs2).
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0.
- rsp0_valid  output  1  result for requester 0.
- rsp0_ready  input  1  requester 0 takes result.
- rsp1_valid  output  1  result for requester 1.
- rsp1_ready  input  1  requester 1 takes result.
- rsp_data  output  XLEN  result, shared by both response channels.
- dp_frs1  output  XLEN  datapath operand 1 (registered).
- dp_frs2  output  XLEN  datapath operand 2 (registered).
- dp_funct  output  1  datapath Funct (0 add, 1 sub).
- dp_en  output  1  datapath enable, high in EXEC.
- dp_frd  input  XLEN  datapath add/sub result.
- dp_min  input  XLEN  datapath MIN.
- dp_max  input  XLEN  datapath MAX.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset: clk is the single clock; rst_n is asynchronous, active-low. Reset forces state=IDLE, last_grant=1, cnt=0, dp_frs1/dp_frs2/rsp_data/op_q=0, owner=0. Every output is 0 during and after reset until a request arrives. Assertion mid-operation drops the in-flight op; no response is issued.
- States: IDLE, EXEC, RESP.
- IDLE:
  - Grant: if only one reqN_valid, grant N. If both, grant the requester != last_grant (req0 wins first after reset).
  - reqN_ready is combinational: high only in IDLE for the granted N, and never while a response is pending.
  - On grant: latch a->dp_frs1, b->dp_frs2, op->op_q, owner=N, last_grant=N, cnt=DP_LAT-1; go to EXEC.
- EXEC:
  - dp_en=1. dp_funct=op_q[0] for add/sub; 1 for min/max, because the datapath derives MIN/MAX from the sign of frs1-frs2.
  - If cnt==0: capture rsp_data (00/01 -> dp_frd, 10 -> dp_min, 11 -> dp_max); go to RESP. Otherwise cnt-1.
- RESP:
  - rsp<owner>_valid=1; the other response valid stays 0. rsp_data and owner are held stable.
  - On rsp<owner>_ready: go to IDLE the next cycle. A new grant is possible that IDLE cycle, never in the same cycle as the handshake.
  - Backpressure is unbounded. New requests wait; req*_ready=0.
- Latency: grant cycle T, result sampled at end of T+DP_LAT, rsp valid from T+DP_LAT+1. Minimum issue interval is DP_LAT+2 cycles.
- Operand registers change only on a grant, so the datapath inputs are stable for the whole of EXEC and RESP.
- The op is never retried. Requester inputs are don't-care once accepted.
- No arithmetic here. NaN and zero handling belong to the datapath.

Test Plan:
- Reset idle: rst_n low, then high, no requests -> all outputs 0, busy=0, state IDLE indefinitely.
- Single add, DP_LAT=2: req0 op=00, a=0x3F800000, b=0x40000000, datapath model returns 0x40400000 -> req0_ready at T; dp_funct=0; rsp0_valid at T+3 with rsp_data=0x40400000; rsp1_valid stays 0.
- Max with backpressure: req1 op=11, a=0xC0000000, b=0x3F800000, rsp1_ready held low 5 cycles -> dp_funct=1; rsp_data=dp_max (0x3F800000) held stable; busy=1 throughout; req0_ready=0 while pending.
- Simultaneous contention: both valid continuously for 4 ops -> grants in order 0,1,0,1; each response goes to the correct channel.
- Async reset in EXEC: pull rst_n low mid-EXEC -> outputs clear immediately, no rsp*_valid after release, the next grant goes to req0.
- DP_LAT=1 boundary: back-to-back req0 ops with rsp0_ready tied high -> grants every 3 cycles, sub op 01 drives dp_funct=1.
